i2c_req_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one i2c_controller between N_REQ on-chip requesters.
- Each requester posts a single-byte I2C transaction (addr, wdata, rw). The arbiter grants one, drives the controller's addr/wdata/rw/enable inputs, and tracks the controller's ready handshake to completion.
- On completion it returns read data and a per-requester done/err pulse.
- Sits between the register/sensor-polling clients and i2c_controller.

---
 rtl/i2c_req_arbiter.sv | 178 +++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_req_arbiter.sv
// ============================================================================
// i2c_req_arbiter
// ----------------------------------------------------------------------------
// Shares one i2c_controller between N_REQ on-chip requesters. Requesters are
// served round-robin. The arbiter latches the winner's single-byte transaction
// into the controller inputs and follows the controller's ready handshake to
// completion. It then returns the captured read byte and pulses done for the
// winner, with err set when the transaction was aborted by a timeout.
//
// Ports:
//   clk, rst      system clock (rising edge); synchronous active-high reset
//   req           per-requester request level, held until its own done
//   req_addr      packed 7-bit slave addresses, requester i at [7i+6:7i]
//   req_wdata     packed write bytes, requester i at [8i+7:8i]
//   req_rw        per-requester direction, 1 = read, 0 = write
//   gnt           one-hot grant, high from issue through completion
//   done          one-cycle completion pulse to the granted requester
//   err           valid with done; 1 = timeout abort
//   rdata         byte captured from m_data_out at completion
//   busy          high whenever a transaction is in flight
//   m_addr        controller slave address (registered)
//   m_wdata       controller write byte (registered)
//   m_rw          controller direction (registered)
//   m_enable      controller enable
//   m_ready       controller ready (1 = idle)
//   m_data_out    controller read data
// ============================================================================
module i2c_req_arbiter #(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned ISSUE_TIMEOUT = 16,
    parameter int unsigned BUSY_TIMEOUT  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [7*N_REQ-1:0]   req_addr,
    input  logic [8*N_REQ-1:0]   req_wdata,
    input  logic [N_REQ-1:0]     req_rw,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic [7:0]           rdata,
    output logic                 busy,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_wdata,
    output logic                 m_rw,
    output logic                 m_enable,
    input  logic                 m_ready,
    input  logic [7:0]           m_data_out
);

    localparam int unsigned IW     = $clog2(N_REQ);
    localparam int unsigned MAX_TO = (ISSUE_TIMEOUT > BUSY_TIMEOUT) ? ISSUE_TIMEOUT : BUSY_TIMEOUT;
    localparam int unsigned CW     = $clog2(MAX_TO) + 1;

    localparam logic [CW-1:0] ISSUE_LAST = CW'(ISSUE_TIMEOUT - 1);
    localparam logic [CW-1:0] BUSY_LAST  = CW'(BUSY_TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_REQ   = IW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_COMPLETE
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic [CW-1:0]   cnt;

    // ------------------------------------------------------------------------
    // Round-robin pick: first asserted request scanning from ptr upward,
    // wrapping modulo N_REQ.
    // ------------------------------------------------------------------------
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [N_REQ-1:0]  pick_onehot;
    int unsigned       scan;

    always_comb begin
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        scan        = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan = (32'(ptr) + k) % N_REQ;
            if (!pick_found && req[IW'(scan)]) begin
                pick_found              = 1'b1;
                pick_idx                = IW'(scan);
                pick_onehot[IW'(scan)]  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer. done/err are set on the edge that enters COMPLETE so that
    // they are visible for exactly the one COMPLETE cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            win      <= '0;
            cnt      <= '0;
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_rw     <= 1'b0;
            m_enable <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (m_ready && pick_found) begin
                        win      <= pick_idx;
                        gnt      <= pick_onehot;
                        m_addr   <= req_addr[7*pick_idx +: 7];
                        m_wdata  <= req_wdata[8*pick_idx +: 8];
                        m_rw     <= req_rw[pick_idx];
                        m_enable <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        state    <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (!m_ready) begin
                        // Controller accepted the request.
                        m_enable <= 1'b0;
                        cnt      <= '0;
                        state    <= S_BUSY;
                    end else if (cnt == ISSUE_LAST) begin
                        m_enable <= 1'b0;
                        err      <= 1'b1;
                        done     <= gnt;
                        state    <= S_COMPLETE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_BUSY: begin
                    if (m_ready) begin
                        rdata <= m_data_out;
                        err   <= 1'b0;
                        done  <= gnt;
                        state <= S_COMPLETE;
                    end else if (cnt == BUSY_LAST) begin
                        err   <= 1'b1;
                        done  <= gnt;
                        state <= S_COMPLETE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_COMPLETE: begin
                    done  <= '0;
                    gnt   <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    ptr   <= (win == LAST_REQ) ? '0 : win + IW'(1);
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// ============================================================================
// tb_i2c_req_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for i2c_req_arbiter. The bench plays both the requesters
// and the i2c_controller. A transaction-level reference model predicts the
// round-robin winner, the latched payload, completion time, err, rdata and
// the number of cycles m_enable stays high from the controller's
// accept delay and busy length.
// ============================================================================
module tb_i2c_req_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned ITO = 16;
    localparam int unsigned BTO = 4096;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [7*N-1:0]   req_addr;
    logic [8*N-1:0]   req_wdata;
    logic [N-1:0]     req_rw;
    logic [N-1:0]     gnt;
    logic [N-1:0]     done;
    logic             err;
    logic [7:0]       rdata;
    logic             busy;
    logic [6:0]       m_addr;
    logic [7:0]       m_wdata;
    logic             m_rw;
    logic             m_enable;
    logic             m_ready;
    logic [7:0]       m_data_out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    int unsigned model_ptr   = 0;
    logic [7:0]  model_rdata = '0;
    logic [7:0]  rd_byte;

    i2c_req_arbiter #(
        .N_REQ(N),
        .ISSUE_TIMEOUT(ITO),
        .BUSY_TIMEOUT(BTO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_rw(req_rw),
        .gnt(gnt),
        .done(done),
        .err(err),
        .rdata(rdata),
        .busy(busy),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_rw(m_rw),
        .m_enable(m_enable),
        .m_ready(m_ready),
        .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(gnt), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_err"},   32'(err), 0);
        check({tag, "_rdata"}, 32'(rdata), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_men"},   32'(m_enable), 0);
        check({tag, "_maddr"}, 32'(m_addr), 0);
        check({tag, "_mwd"},   32'(m_wdata), 0);
        check({tag, "_mrw"},   32'(m_rw), 0);
    endtask

    // Pulse reset while idle; called and returns at a negedge.
    task automatic do_reset();
        rst     = 1'b1;
        m_ready = 1'b1;
        req     = '0;
        @(negedge clk);
        check_all_zero("reset");
        rst         = 1'b0;
        model_ptr   = 0;
        model_rdata = '0;
    endtask

    // One complete transaction. Called at a negedge with the DUT idle.
    //   reqs : request vector presented for arbitration
    //   a    : cycles the controller keeps ready high after enable (>=ITO: never accepts)
    //   b    : cycles ready stays low after acceptance (>BTO: never returns)
    //   hold : winner keeps req asserted throughout (else drops it after grant)
    task automatic run_txn(input logic [N-1:0] reqs, input int unsigned a,
                           input int unsigned b, input bit hold);
        int unsigned w, i, exp_t, exp_en, en_cnt;
        logic [N-1:0] exp_g;
        logic [6:0]   exp_addr;
        logic [7:0]   exp_wd;
        logic         exp_rw;
        bit           exp_err, got_done;
        logic [7:0]   exp_rd;

        w = N;
        for (int unsigned k = 0; k < N; k++) begin
            i = (model_ptr + k) % N;
            if (w == N && reqs[i]) w = i;
        end
        exp_g    = '0;
        exp_g[w] = 1'b1;
        exp_addr = req_addr[7*w +: 7];
        exp_wd   = req_wdata[8*w +: 8];
        exp_rw   = req_rw[w];
        exp_err  = (a >= ITO) || (b > BTO);
        exp_t    = (a >= ITO) ? ITO : a + 1 + ((b > BTO) ? BTO : b);
        exp_en   = (a >= ITO) ? ITO : a + 1;
        exp_rd   = exp_err ? model_rdata : rd_byte;

        req     = reqs;
        m_ready = 1'b1;
        @(negedge clk);
        check("grant_latency", 32'(m_enable), 1);
        check("gnt", 32'(gnt), 32'(exp_g));
        check("m_addr", 32'(m_addr), 32'(exp_addr));
        check("m_wdata", 32'(m_wdata), 32'(exp_wd));
        check("m_rw", 32'(m_rw), 32'(exp_rw));
        check("busy_on", 32'(busy), 1);

        en_cnt   = 0;
        got_done = 1'b0;
        for (int unsigned t = 0; t <= exp_t + 4; t++) begin
            if (t > 0) @(negedge clk);
            if (m_enable) en_cnt++;
            if (done != '0) begin
                check("done_time", t, exp_t);
                check("done_vec", 32'(done), 32'(exp_g));
                check("err", 32'(err), 32'(exp_err));
                check("rdata", 32'(rdata), 32'(exp_rd));
                check("gnt_at_done", 32'(gnt), 32'(exp_g));
                got_done = 1'b1;
                break;
            end
            // Controller model drives inputs for the next edge.
            if (t == a) m_ready = 1'b0;
            if (a < ITO && t == a + b) begin
                m_ready    = 1'b1;
                m_data_out = rd_byte;
            end else begin
                m_data_out = 8'($urandom);
            end
            if (!hold && t == 0) req[w] = 1'b0;
            // Non-granted requesters are free to change anything.
            for (int unsigned j = 0; j < N; j++) begin
                if (j != w && $urandom_range(0, 3) == 0) begin
                    req[j]              = 1'($urandom_range(0, 1));
                    req_addr[7*j +: 7]  = 7'($urandom);
                    req_wdata[8*j +: 8] = 8'($urandom);
                    req_rw[j]           = 1'($urandom_range(0, 1));
                end
            end
        end
        if (!got_done) check("done_timeout", 0, 1);
        check("enable_cycles", en_cnt, exp_en);

        // Requests stay visible during COMPLETE; no grant may occur there.
        m_ready = 1'b1;
        req     = hold ? reqs : '0;
        @(negedge clk);
        check("done_clear", 32'(done), 0);
        check("gnt_clear", 32'(gnt), 0);
        check("err_clear", 32'(err), 0);
        check("busy_clear", 32'(busy), 0);
        check("no_arb_complete", 32'(m_enable), 0);

        model_ptr = (w + 1) % N;
        if (!exp_err) model_rdata = rd_byte;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        req        = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_rw     = '0;
        m_ready    = 1'b1;
        m_data_out = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single write from requester 0
        req_addr[6:0]  = 7'h55;
        req_wdata[7:0] = 8'hA5;
        req_rw[0]      = 1'b0;
        rd_byte        = 8'($urandom);
        run_txn(4'b0001, 2, 40, 1'b1);

        // Read capture from requester 2
        req_addr[20:14] = 7'h1A;
        req_rw[2]       = 1'b1;
        rd_byte         = 8'h3C;
        run_txn(4'b0100, 3, 12, 1'b1);

        // Controller not ready in IDLE: no grant
        m_ready = 1'b0;
        req     = 4'b1000;
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_not_ready_en", 32'(m_enable), 0);
            check("idle_not_ready_gnt", 32'(gnt), 0);
        end
        rd_byte = 8'($urandom);
        run_txn(4'b1000, 1, 5, 1'b0);

        // Round-robin from a known pointer: 0,1,2,3,0,1 then 1010 -> 3, 1
        do_reset();
        for (int unsigned k = 0; k < 6; k++) begin
            rd_byte = 8'($urandom);
            run_txn(4'b1111, 1, 7, 1'b1);
        end
        rd_byte = 8'($urandom);
        run_txn(4'b1010, 1, 7, 1'b1);
        rd_byte = 8'($urandom);
        run_txn(4'b1010, 1, 7, 1'b1);

        // Issue timeout and its boundary
        rd_byte = 8'($urandom);
        run_txn(4'b0001, 20, 1, 1'b1);
        rd_byte = 8'($urandom);
        run_txn(4'b0010, ITO - 1, 3, 1'b1);

        // Busy timeout and its boundary
        rd_byte = 8'($urandom);
        run_txn(4'b0100, 2, 5000, 1'b1);
        rd_byte = 8'($urandom);
        run_txn(4'b1000, 2, BTO, 1'b1);

        // Reset during BUSY of requester 1
        req     = 4'b0010;
        m_ready = 1'b1;
        @(negedge clk);
        check("rst_test_gnt", 32'(gnt), 32'(4'b0010));
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_test_busy", 32'(busy), 1);
        rst     = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        check_all_zero("midbusy_reset");
        rst         = 1'b0;
        req         = '0;
        model_ptr   = 0;
        model_rdata = '0;
        @(negedge clk);
        check("after_reset_done", 32'(done), 0);
        rd_byte = 8'($urandom);
        run_txn(4'b0011, 1, 5, 1'b1);

        // Randomized traffic
        for (int unsigned k = 0; k < 40; k++) begin
            req_addr  = 28'($urandom);
            req_wdata = $urandom;
            req_rw    = 4'($urandom);
            rd_byte   = 8'($urandom);
            run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 18),
                    $urandom_range(1, 30), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
